// File: rtl/board_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | board_pkg: cell codes and arbiter state shared by the board RAM  |
// | arbiter and the color decoder.                                   |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
package board_pkg;

  localparam int CODE_W = 3;

  typedef enum logic [CODE_W-1:0] {
    EMPTY  = 3'b000,
    RED    = 3'b001,
    GREEN  = 3'b010,
    BLUE   = 3'b011,
    YELLOW = 3'b100
  } cell_code_e;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/pix_to_cell.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pix_to_cell: maps a display pixel to a board cell address and    |
// | flags whether the pixel lies on the board.                       |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module pix_to_cell #(
  parameter int COLS       = 8,
  parameter int ROWS       = 8,
  parameter int CELL_SHIFT = 4,
  parameter int ADDR_W     = 6
) (
  input  logic [9:0]        i_pix_x,
  input  logic [8:0]        i_pix_y,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_in_board
);

  logic [9:0] w_col;
  logic [8:0] w_row;

  assign w_col      = i_pix_x >> CELL_SHIFT;
  assign w_row      = i_pix_y >> CELL_SHIFT;
  assign o_in_board = (32'(w_col) < 32'(COLS)) && (32'(w_row) < 32'(ROWS));
  assign o_addr     = ADDR_W'(32'(w_row) * 32'(COLS) + 32'(w_col));

endmodule
`default_nettype wire

// File: rtl/board_arbiter.sv
`default_nettype none
// +------------------------------------------------------------------+
// | board_arbiter: shares the single-port board RAM between display  |
// | reads, game-logic writes and a board-clear sequencer.            |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module board_arbiter
  import board_pkg::*;
#(
  parameter int COLS       = 8,
  parameter int ROWS       = 8,
  parameter int CELL_SHIFT = 4,
  parameter int ADDR_W     = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pix_valid,
  input  logic [9:0]        pix_x,
  input  logic [8:0]        pix_y,
  output logic              pix_code_valid,
  output logic [CODE_W-1:0] pix_code,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [CODE_W-1:0] wr_data,
  output logic              wr_ack,
  input  logic              board_clr,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [CODE_W-1:0] ram_wdata,
  input  logic [CODE_W-1:0] ram_rdata
);

  localparam int                CELLS     = COLS * ROWS;
  localparam logic [ADDR_W-1:0] LAST_CELL = ADDR_W'(CELLS - 1);

  arb_state_e        r_state;
  arb_state_e        w_next_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] w_pix_addr;
  logic              w_in_board;
  logic              w_claim;
  logic              w_we;
  logic              w_ack;
  logic [ADDR_W-1:0] w_addr;
  logic [CODE_W-1:0] w_wdata;
  logic [ADDR_W-1:0] r_ram_addr;
  logic              r_ram_we;
  logic [CODE_W-1:0] r_ram_wdata;
  logic              r_wr_ack;
  logic              r_p1_valid;
  logic              r_p1_use;
  logic              r_p2_valid;
  logic              r_p2_use;
  logic              r_pix_code_valid;
  logic [CODE_W-1:0] r_pix_code;

  pix_to_cell #(
    .COLS       (COLS),
    .ROWS       (ROWS),
    .CELL_SHIFT (CELL_SHIFT),
    .ADDR_W     (ADDR_W)
  ) u_pix_to_cell (
    .i_pix_x    (pix_x),
    .i_pix_y    (pix_y),
    .o_addr     (w_pix_addr),
    .o_in_board (w_in_board)
  );

  assign w_claim = pix_valid && w_in_board;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:  if (board_clr)          w_next_state = ST_CLEAR;
      ST_CLEAR: if (r_cnt == LAST_CELL) w_next_state = ST_IDLE;
      default:                          w_next_state = ST_IDLE;
    endcase
  end

  // Display always wins in IDLE; a write only takes a cycle the display leaves free.
  always_comb begin
    w_we    = 1'b0;
    w_ack   = 1'b0;
    w_addr  = r_ram_addr;
    w_wdata = r_ram_wdata;
    case (r_state)
      ST_IDLE: begin
        if (w_claim) begin
          w_addr = w_pix_addr;
        end else if (wr_req && !board_clr) begin
          w_we    = 1'b1;
          w_ack   = 1'b1;
          w_addr  = wr_addr;
          w_wdata = wr_data;
        end
      end
      ST_CLEAR: begin
        w_we    = 1'b1;
        w_addr  = r_cnt;
        w_wdata = EMPTY;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt       <= '0;
      r_ram_addr  <= '0;
      r_ram_we    <= 1'b0;
      r_ram_wdata <= '0;
      r_wr_ack    <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && board_clr) r_cnt <= '0;
      else if (r_state == ST_CLEAR)        r_cnt <= (r_cnt == LAST_CELL) ? '0 : r_cnt + ADDR_W'(1);
      r_ram_addr  <= w_addr;
      r_ram_we    <= w_we;
      r_ram_wdata <= w_wdata;
      r_wr_ack    <= w_ack;
    end
  end

  // Two-stage flag pipeline lines up with the RAM's one-edge read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_p1_valid       <= 1'b0;
      r_p1_use         <= 1'b0;
      r_p2_valid       <= 1'b0;
      r_p2_use         <= 1'b0;
      r_pix_code_valid <= 1'b0;
      r_pix_code       <= '0;
    end else begin
      r_p1_valid       <= pix_valid;
      r_p1_use         <= w_claim && (r_state == ST_IDLE);
      r_p2_valid       <= r_p1_valid;
      r_p2_use         <= r_p1_use;
      r_pix_code_valid <= r_p2_valid;
      r_pix_code       <= r_p2_use ? ram_rdata : EMPTY;
    end
  end

  assign pix_code_valid = r_pix_code_valid;
  assign pix_code       = r_pix_code;
  assign wr_ack         = r_wr_ack;
  assign busy           = (r_state == ST_CLEAR);
  assign ram_addr       = r_ram_addr;
  assign ram_we         = r_ram_we;
  assign ram_wdata      = r_ram_wdata;

endmodule
`default_nettype wire
